// File: rtl/huff_pkg.sv
// Constants and encodings shared by the Huffman encode blocks.
package huff_pkg;

    localparam logic [5:0] END_SYM = 6'b010010;

    localparam int BUS_WIDTH_DEF = 64;
    localparam int LEN_WIDTH_DEF = 7;
    localparam int OUT_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_LAST  = 2'd2,
        ST_DONE  = 2'd3
    } pack_state_t;

endpackage

// File: rtl/huff_bit_packer_if.sv
// Code-in / word-out handshake bundle of the bit packer.
interface huff_bit_packer_if
    import huff_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
);
    logic                 in_valid;
    logic [BUS_WIDTH-1:0] code;
    logic [LEN_WIDTH-1:0] len;
    logic                 in_ready;
    logic                 flush;
    logic                 out_valid;
    logic [OUT_WIDTH-1:0] out_data;
    logic [LEN_WIDTH-1:0] out_bits;
    logic                 out_last;
    logic                 out_ready;
    logic                 flush_done;

    modport master (
        output in_valid, code, len, flush, out_ready,
        input  in_ready, out_valid, out_data, out_bits, out_last, flush_done
    );

    modport slave (
        input  in_valid, code, len, flush, out_ready,
        output in_ready, out_valid, out_data, out_bits, out_last, flush_done
    );
endinterface

// File: rtl/huff_len_mask.sv
// Clamps a code length to the bus width and builds the matching low-bit mask.
module huff_len_mask
    import huff_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF
) (
    input  logic [LEN_WIDTH-1:0] len,
    output logic [LEN_WIDTH-1:0] len_c,
    output logic [BUS_WIDTH-1:0] mask
);
    localparam logic [LEN_WIDTH-1:0] BUS_L = LEN_WIDTH'(BUS_WIDTH);

    always_comb begin
        len_c = (len > BUS_L) ? BUS_L : len;
        mask  = '0;
        for (int i = 0; i < BUS_WIDTH; i++) begin
            mask[i] = (i < int'(len_c));
        end
    end
endmodule

// File: rtl/huff_bit_packer.sv
// Packs variable-length codes LSB-first into fixed-width words, with flush of the tail.
module huff_bit_packer
    import huff_pkg::*;
#(
    parameter int BUS_WIDTH = BUS_WIDTH_DEF,
    parameter int LEN_WIDTH = LEN_WIDTH_DEF,
    parameter int OUT_WIDTH = OUT_WIDTH_DEF
) (
    input logic              clk,
    input logic              rst,
    huff_bit_packer_if.slave bus
);
    localparam int ACC_W  = BUS_WIDTH + OUT_WIDTH;
    localparam int FILL_W = $clog2(ACC_W);
    localparam logic [FILL_W-1:0]    OUT_F = FILL_W'(OUT_WIDTH);
    localparam logic [LEN_WIDTH-1:0] OUT_L = LEN_WIDTH'(OUT_WIDTH);

    pack_state_t          state;
    logic [ACC_W-1:0]     acc, acc_base, acc_nxt;
    logic [FILL_W-1:0]    fill, fill_base, fill_nxt;
    logic [LEN_WIDTH-1:0] len_c;
    logic [BUS_WIDTH-1:0] len_mask;
    logic                 in_ready_i, out_valid_i, accept, emit;

    huff_len_mask #(
        .BUS_WIDTH (BUS_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_len_mask (
        .len   (bus.len),
        .len_c (len_c),
        .mask  (len_mask)
    );

    // Where the drain goes once the current word (if any) has left.
    function automatic pack_state_t drain_state(input logic [FILL_W-1:0] f);
        if (f >= OUT_F)     return ST_FLUSH;
        else if (f != '0)   return ST_LAST;
        else                return ST_DONE;
    endfunction

    assign in_ready_i  = (state == ST_RUN) && (fill < OUT_F);
    assign out_valid_i = (fill >= OUT_F) || (state == ST_LAST);
    assign accept      = bus.in_valid && in_ready_i;
    assign emit        = out_valid_i && bus.out_ready;

    // Shift the outgoing word out first, then OR the new code in above what remains.
    always_comb begin
        acc_base  = acc;
        fill_base = fill;
        if (emit) begin
            acc_base  = acc >> OUT_WIDTH;
            fill_base = (state == ST_LAST) ? '0 : fill - OUT_F;
        end
        acc_nxt  = acc_base;
        fill_nxt = fill_base;
        if (accept) begin
            acc_nxt  = acc_base | (ACC_W'(bus.code & len_mask) << fill_base);
            fill_nxt = fill_base + FILL_W'(len_c);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            acc   <= '0;
            fill  <= '0;
        end else begin
            acc  <= acc_nxt;
            fill <= fill_nxt;
            unique case (state)
                ST_RUN:   if (bus.flush) state <= drain_state(fill_nxt);
                ST_FLUSH: state <= drain_state(fill_nxt);
                ST_LAST:  if (emit) state <= ST_DONE;
                ST_DONE:  state <= ST_RUN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_i;
    assign bus.out_valid  = out_valid_i;
    assign bus.out_data   = acc[OUT_WIDTH-1:0];
    assign bus.out_bits   = (state == ST_LAST) ? LEN_WIDTH'(fill) :
                            (out_valid_i ? OUT_L : '0);
    // A full word ends the flush only when nothing is left behind it.
    assign bus.out_last   = (state == ST_LAST) || ((state == ST_FLUSH) && (fill == OUT_F));
    assign bus.flush_done = (state == ST_DONE);
endmodule

// File: tb/tb_huff_bit_packer.sv
// Directed bench for huff_bit_packer with hand-computed expected words.
module tb_huff_bit_packer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    huff_bit_packer_if #(.BUS_WIDTH(64), .LEN_WIDTH(7), .OUT_WIDTH(32)) bus ();

    huff_bit_packer #(.BUS_WIDTH(64), .LEN_WIDTH(7), .OUT_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_word(input string tag, input logic [31:0] data,
                              input logic [6:0] bits, input logic last);
        check({tag, ".valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".data"},  64'(bus.out_data),  64'(data));
        check({tag, ".bits"},  64'(bus.out_bits),  64'(bits));
        check({tag, ".last"},  64'(bus.out_last),  64'(last));
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.code      = '0;
        bus.len       = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset and idle
        step();
        step();
        rst = 1'b0;
        check("rst.out_bits",   64'(bus.out_bits),   64'd0);
        check("rst.out_last",   64'(bus.out_last),   64'd0);
        check("rst.flush_done", 64'(bus.flush_done), 64'd0);
        for (int i = 0; i < 10; i++) begin
            check("idle.out_valid", 64'(bus.out_valid), 64'd0);
            check("idle.in_ready",  64'(bus.in_ready),  64'd1);
            check("idle.out_data",  64'(bus.out_data),  64'd0);
            step();
        end

        // Eleven 3-bit codes 0b101, then flush
        bus.in_valid = 1'b1;
        bus.code     = 64'h5;
        bus.len      = 7'd3;
        for (int i = 0; i < 11; i++) begin
            check("pack3.in_ready", 64'(bus.in_ready), 64'd1);
            step();
        end
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        check_word("pack3.w0", 32'h6DB6DB6D, 7'd32, 1'b0);
        check("pack3.in_ready_full", 64'(bus.in_ready), 64'd0);
        step();
        bus.flush = 1'b0;
        check_word("pack3.last", 32'h1, 7'd1, 1'b1);
        check("pack3.done_early", 64'(bus.flush_done), 64'd0);
        step();
        check("pack3.flush_done", 64'(bus.flush_done), 64'd1);
        check("pack3.valid_done", 64'(bus.out_valid),  64'd0);
        step();
        check("pack3.done_clear", 64'(bus.flush_done), 64'd0);
        check("pack3.ready_back", 64'(bus.in_ready),   64'd1);

        // Full 64-bit code under backpressure
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.code      = 64'hFFFF_FFFF_0000_0001;
        bus.len       = 7'd64;
        step();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp.in_ready", 64'(bus.in_ready), 64'd0);
            check_word("bp.hold", 32'h1, 7'd32, 1'b0);
            step();
        end
        bus.out_ready = 1'b1;
        check_word("bp.w0", 32'h1, 7'd32, 1'b0);
        step();
        check_word("bp.w1", 32'hFFFF_FFFF, 7'd32, 1'b0);
        step();
        check("bp.empty_valid", 64'(bus.out_valid), 64'd0);
        check("bp.empty_ready", 64'(bus.in_ready),  64'd1);

        // Code bits above len are masked
        bus.in_valid = 1'b1;
        bus.code     = 64'hFF;
        bus.len      = 7'd5;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        check("mask.no_word", 64'(bus.out_valid), 64'd0);
        step();
        bus.flush = 1'b0;
        check_word("mask.last", 32'h1F, 7'd5, 1'b1);
        step();
        check("mask.flush_done", 64'(bus.flush_done), 64'd1);
        step();

        // Oversized len clamps to 64: flush yields two full words, second marked last
        bus.in_valid = 1'b1;
        bus.code     = '1;
        bus.len      = 7'd127;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        check_word("clamp.w0", 32'hFFFF_FFFF, 7'd32, 1'b0);
        step();
        bus.flush = 1'b0;
        check_word("clamp.w1", 32'hFFFF_FFFF, 7'd32, 1'b1);
        step();
        check("clamp.flush_done", 64'(bus.flush_done), 64'd1);
        check("clamp.no_last",    64'(bus.out_valid),  64'd0);
        step();

        // len 0 is a no-op; flush of an empty packer pulses flush_done next cycle
        bus.in_valid = 1'b1;
        bus.code     = 64'hFF;
        bus.len      = 7'd0;
        step();
        bus.in_valid = 1'b0;
        check("len0.valid", 64'(bus.out_valid), 64'd0);
        check("len0.ready", 64'(bus.in_ready),  64'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("empty.flush_done", 64'(bus.flush_done), 64'd1);
        check("empty.valid",      64'(bus.out_valid),  64'd0);
        step();
        check("empty.done_clear", 64'(bus.flush_done), 64'd0);

        // Flush repeated in FLUSH is ignored; reset discards 40 buffered bits
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.code      = 64'h12_3456_789A;
        bus.len       = 7'd40;
        step();
        bus.in_valid = 1'b0;
        bus.flush    = 1'b1;
        step();
        step();
        bus.flush = 1'b0;
        check_word("fl40.word", 32'h3456_789A, 7'd32, 1'b0);
        check("fl40.in_ready",   64'(bus.in_ready),   64'd0);
        check("fl40.flush_done", 64'(bus.flush_done), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        check("rst40.valid",    64'(bus.out_valid), 64'd0);
        check("rst40.in_ready", 64'(bus.in_ready),  64'd1);
        check("rst40.data",     64'(bus.out_data),  64'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst40.no_last", 64'(bus.out_valid),  64'd0);
            check("rst40.no_done", 64'(bus.flush_done), 64'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
